slave_out_port: RTL and testbench



---
 rtl/slave_out_port.sv | 114 +++++++++++
 tb/tb_slave_out_port.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/slave_out_port.sv
// Slave-side serialiser: hands one DATA_LEN-bit read word to the master input
// port over a slave_valid/master_ready handshake, then streams it LSB first.
module slave_out_port #(
  parameter int DATA_LEN = 8,
  parameter int TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tx_start,
  input  logic [DATA_LEN-1:0] data_in,
  output logic                busy,
  output logic                tx_done,
  output logic                timeout_err,
  output logic                tx_data,
  output logic                slave_valid,
  input  logic                master_ready
);

  localparam int BW = $clog2(DATA_LEN);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HANDSHAKE,
    SEND
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_LEN-1:0] shift_reg, shift_nxt;
  logic [BW-1:0]       bit_cnt, bit_nxt;
  logic [WW-1:0]       wait_cnt, wait_nxt;
  logic                valid_nxt, done_nxt, terr_nxt, busy_nxt;

  // All outputs come straight from these registers; reset drops slave_valid at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      slave_valid <= 1'b0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_reg   <= shift_nxt;
      bit_cnt     <= bit_nxt;
      wait_cnt    <= wait_nxt;
      slave_valid <= valid_nxt;
      tx_done     <= done_nxt;
      timeout_err <= terr_nxt;
      busy        <= busy_nxt;
    end
  end

  // The handshake edge already delivers bit 0, so SEND starts with bit 1 on the line.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    bit_nxt   = bit_cnt;
    wait_nxt  = wait_cnt;
    valid_nxt = slave_valid;
    done_nxt  = 1'b0;
    terr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          shift_nxt = data_in;
          valid_nxt = 1'b1;
          wait_nxt  = '0;
          state_nxt = WAIT_HANDSHAKE;
        end
      end
      WAIT_HANDSHAKE: begin
        if (master_ready) begin
          shift_nxt = shift_reg >> 1;
          bit_nxt   = BW'(1);
          valid_nxt = 1'b0;
          state_nxt = SEND;
        end else if ((TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT - 1))) begin
          shift_nxt = '0;
          valid_nxt = 1'b0;
          terr_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      SEND: begin
        if (bit_cnt == BW'(DATA_LEN - 1)) begin
          shift_nxt = '0;
          bit_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          shift_nxt = shift_reg >> 1;
          bit_nxt   = bit_cnt + 1'b1;
        end
      end
      default: begin
        shift_nxt = '0;
        bit_nxt   = '0;
        wait_nxt  = '0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign tx_data = shift_reg[0];

endmodule

// File: tb/tb_slave_out_port.sv
// Bench for slave_out_port: two instances (wait-forever and TIMEOUT=4) share one
// stimulus stream and are each checked every cycle against a word-level model.
module tb_slave_out_port;

  localparam int DATA_LEN = 8;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       master_ready;
  logic [7:0] data_in;
  logic       busy [N];
  logic       tx_done [N];
  logic       timeout_err [N];
  logic       tx_data [N];
  logic       slave_valid [N];

  slave_out_port #(.DATA_LEN(DATA_LEN), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .data_in(data_in),
    .busy(busy[0]), .tx_done(tx_done[0]), .timeout_err(timeout_err[0]),
    .tx_data(tx_data[0]), .slave_valid(slave_valid[0]), .master_ready(master_ready)
  );

  slave_out_port #(.DATA_LEN(DATA_LEN), .TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .data_in(data_in),
    .busy(busy[1]), .tx_done(tx_done[1]), .timeout_err(timeout_err[1]),
    .tx_data(tx_data[1]), .slave_valid(slave_valid[1]), .master_ready(master_ready)
  );

  always #5 clk = ~clk;

  int         tmo [N];
  bit         m_active [N];
  bit         m_hs [N];
  int         m_waited [N];
  int         m_sent [N];
  logic [7:0] m_word [N];
  bit         m_done [N];
  bit         m_terr [N];
  logic [7:0] rx_word [N];
  logic       last_tx [N];
  int         terr_seen [N];
  int         done_seen [N];
  logic [7:0] rx_q [$];
  int         checks = 0;
  int         errors = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0;
      m_hs[i]     = 0;
      m_waited[i] = 0;
      m_sent[i]   = 0;
      m_word[i]   = '0;
      m_done[i]   = 0;
      m_terr[i]   = 0;
      rx_word[i]  = '0;
    end
  endtask

  // Word-level view: a word is pending until the handshake, then m_sent bits
  // have been delivered; the master's captures are taken from the DUT line.
  task automatic model_edge(input int i);
    m_done[i] = 0;
    m_terr[i] = 0;
    if (!m_active[i]) begin
      if (tx_start) begin
        m_active[i] = 1;
        m_hs[i]     = 0;
        m_waited[i] = 0;
        m_word[i]   = data_in;
      end
    end else if (!m_hs[i]) begin
      if (master_ready) begin
        rx_word[i][0] = last_tx[i];
        m_hs[i]       = 1;
        m_sent[i]     = 1;
      end else if (tmo[i] != 0 && m_waited[i] == tmo[i] - 1) begin
        m_active[i] = 0;
        m_terr[i]   = 1;
      end else begin
        m_waited[i]++;
      end
    end else begin
      rx_word[i][m_sent[i]] = last_tx[i];
      if (m_sent[i] == DATA_LEN - 1) begin
        m_active[i] = 0;
        m_done[i]   = 1;
        check_output($sformatf("rx_word%0d", i), 32'(rx_word[i]), 32'(m_word[i]));
        if (i == 0) rx_q.push_back(rx_word[i]);
      end else begin
        m_sent[i]++;
      end
    end
  endtask

  task automatic check_all();
    logic exp_tx;
    for (int i = 0; i < N; i++) begin
      exp_tx = m_active[i] ? m_word[i][m_hs[i] ? m_sent[i] : 0] : 1'b0;
      check_output($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_active[i]));
      check_output($sformatf("slave_valid%0d", i), 32'(slave_valid[i]), 32'(m_active[i] && !m_hs[i]));
      check_output($sformatf("tx_data%0d", i), 32'(tx_data[i]), 32'(exp_tx));
      check_output($sformatf("tx_done%0d", i), 32'(tx_done[i]), 32'(m_done[i]));
      check_output($sformatf("timeout_err%0d", i), 32'(timeout_err[i]), 32'(m_terr[i]));
      if (timeout_err[i] === 1'b1) terr_seen[i]++;
      if (tx_done[i] === 1'b1) done_seen[i]++;
      last_tx[i] = tx_data[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i);
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_stimulus(input logic start, input logic [7:0] data, input logic ready);
    tx_start     = start;
    data_in      = data;
    master_ready = ready;
    tick();
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    check_output(tag, 32'(got), 32'(exp));
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      terr_seen[i] = 0;
      done_seen[i] = 0;
    end
  endtask

  initial begin
    int done_snap;
    tmo[0] = 0;
    tmo[1] = 4;
    reset = 1'b1;
    tx_start = 1'b0;
    master_ready = 1'b0;
    data_in = '0;
    model_reset();
    clear_counts();
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single word 8'hA5, master always ready");
    apply_stimulus(1'b1, 8'hA5, 1'b1);
    repeat (9) apply_stimulus(1'b0, 8'hA5, 1'b1);
    pop_rx("word_a5", 8'hA5);

    $display("[TB] 8'h3C with master_ready low for 5 cycles");
    clear_counts();
    apply_stimulus(1'b1, 8'h3C, 1'b0);
    repeat (5) apply_stimulus(1'b0, 8'h3C, 1'b0);
    repeat (9) apply_stimulus(1'b0, 8'h3C, 1'b1);
    pop_rx("word_3c", 8'h3C);
    check_output("t1_abort_3c", 32'(terr_seen[1]), 32'd1);

    $display("[TB] 8'hFF with master never ready");
    clear_counts();
    apply_stimulus(1'b1, 8'hFF, 1'b0);
    repeat (8) apply_stimulus(1'b0, 8'hFF, 1'b0);
    check_output("t1_terr_count", 32'(terr_seen[1]), 32'd1);
    check_output("t1_done_count", 32'(done_seen[1]), 32'd0);
    check_output("t0_still_waiting", 32'(busy[0]), 32'd1);
    repeat (9) apply_stimulus(1'b0, 8'h00, 1'b1);
    pop_rx("word_ff", 8'hFF);

    $display("[TB] back-to-back 8'h01 then 8'h80 with tx_start held");
    apply_stimulus(1'b1, 8'h01, 1'b1);
    repeat (9) apply_stimulus(1'b1, 8'h80, 1'b1);
    repeat (9) apply_stimulus(1'b0, 8'h80, 1'b1);
    pop_rx("word_01", 8'h01);
    pop_rx("word_80", 8'h80);

    $display("[TB] reset during bit 3 of 8'hC3");
    apply_stimulus(1'b1, 8'hC3, 1'b1);
    repeat (3) apply_stimulus(1'b0, 8'hC3, 1'b1);
    check_output("c3_bit3", 32'(tx_data[0]), 32'd0);
    done_snap = done_seen[0];
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
    check_output("no_done_on_reset", 32'(done_seen[0]), 32'(done_snap));
    apply_stimulus(1'b1, 8'h5A, 1'b1);
    repeat (9) apply_stimulus(1'b0, 8'h5A, 1'b1);
    pop_rx("word_5a", 8'h5A);

    $display("[TB] data_in cleared during SEND of 8'h96");
    apply_stimulus(1'b1, 8'h96, 1'b1);
    repeat (9) apply_stimulus(1'b0, 8'h00, 1'b1);
    pop_rx("word_96", 8'h96);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++)
      apply_stimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 9) < 6);
    repeat (12) apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("drain_idle0", 32'(busy[0]), 32'd0);
    check_output("drain_idle1", 32'(busy[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
